z_frame_uart_sender: RTL and testbench
======================================

# z_frame_uart_sender

Drains one captured IR frame from the capture FIFO's read side and streams it out as an 8N1 UART byte stream on a single pin. It sits downstream of the frame-capture block: that block fills the FIFO and pulses frame-done, and this block reads the FIFO back and serialises the frame. Each frame goes out as a packet: 2-byte sync header, payload (each 16-bit FIFO word sent high byte first), then a 1-byte additive checksum.

## Interface
- FRAME_WORDS, 19200, 16-bit words per frame; word counter width is $clog2(FRAME_WORDS+1)
- CLK_DIV, 434, iClk cycles per UART bit, minimum 4
- iClk  in  1  system clock; also driven out as the FIFO read clock
- iRst_N  in  1  asynchronous active-low reset
- iEn  in  1  block enable
- iFrameDone  in  1  one-cycle pulse from the capture side: a full frame is in the FIFO
- oFIFO_Rd_Clk  out  1  equals iClk
- oFIFO_Rd_En  out  1  FIFO read strobe, one cycle per word
- iFIFO_Rd_Data  in  16  FIFO output; valid the cycle after oFIFO_Rd_En
- iFIFO_Empty  in  1  FIFO empty flag
- oUART_Tx  out  1  serial output, idle high
- oBusy  out  1  high from accepted start until the final stop bit ends
- oFrameSent  out  1  one-cycle pulse when the checksum stop bit completes

## Operation
- Reset values: oUART_Tx=1, oFIFO_Rd_En=0, oBusy=0, oFrameSent=0. Counters, checksum and pending byte are cleared.
- Packet byte order: 0x55, 0xAA, then for w = 0..FRAME_WORDS-1 the bytes word[15:8] and word[7:0], then CHK. CHK is the sum of all payload bytes mod 256; header bytes are not included.
- UART framing: start bit 0, 8 data bits LSB first, stop bit 1. Every bit is held exactly CLK_DIV cycles.
- Control FSM states: IDLE, HDR0, HDR1, RD_REQ, RD_WAIT, HI, LO, CHK, DONE.
  - IDLE: moves to HDR0 only when iFrameDone=1 and iEn=1.
  - HDR0 -> HDR1 -> RD_REQ, advancing as each byte is handed to the serialiser.
  - RD_REQ: holds while iFIFO_Empty=1. Otherwise asserts oFIFO_Rd_En for one cycle and goes to RD_WAIT.
  - RD_WAIT: latches iFIFO_Rd_Data, then goes to HI.
  - HI -> LO.
  - LO: goes to RD_REQ if words remain, otherwise CHK.
  - CHK -> DONE.
  - DONE: waits for the serialiser to go idle, pulses oFrameSent, returns to IDLE.
- Byte handoff uses a one-entry pending register. The FSM loads it when it is empty. The serialiser takes it at the start of each byte, so the next byte is prefetched while the current byte shifts.
- iFrameDone while oBusy=1 is ignored; it is not queued.
- iEn falling mid-packet: no new byte is loaded. The byte currently shifting completes, then the block returns to IDLE. No oFrameSent; oBusy drops after that stop bit. The rest of the FIFO is left unread.
- FIFO empty mid-frame: the block stalls in RD_REQ indefinitely with oUART_Tx idle high between bytes. There is no timeout and no error flag.
- Reset mid-packet forces all reset values immediately, even mid-bit.

## Timing
- Start latency: iFrameDone sampled at edge N. The state is HDR0 after edge N. oUART_Tx falls after edge N+2.
- Byte duration: exactly 10*CLK_DIV cycles.
- While the FIFO stays non-empty, bytes are back-to-back: the next start bit begins on the cycle after the previous stop bit ends. The FIFO read latency, 2 cycles, is hidden inside the preceding byte time, which is why CLK_DIV ≥ 4 is required.
- Packet length with no stalls: (2*FRAME_WORDS+3)*10*CLK_DIV cycles.
- oFrameSent is asserted in the cycle after the last stop bit's final cycle. oBusy falls in that same cycle.
- Exactly FRAME_WORDS oFIFO_Rd_En pulses per completed packet. oFIFO_Rd_En is never asserted while iFIFO_Empty=1.

## Structure
- Package zfu_pkg holds:
  - SYNC0=8'h55 and SYNC1=8'hAA
  - the control state enum
  - UART_BITS=10
- Sub-module z_uart_byte_tx is the natural split: a bit-rate counter and a shift register. Interface: iData[7:0], iValid, oReady, oTx, parameter CLK_DIV.
- The top level holds the FSM, word counter, checksum accumulator and pending register.

## Test plan
- FRAME_WORDS=4, CLK_DIV=4, FIFO preloaded with 0x1234, 0x0001, 0xABCD, 0x00FF, then iFrameDone -> UART decodes 55 AA 12 34 00 01 AB CD 00 FF BE. Exactly 4 read strobes, one oFrameSent, total 110*4 cycles.
- Same load, FIFO empty after word 2 for 200 cycles -> oUART_Tx held high during the stall, then the stream resumes with identical bytes and checksum 0xBE.
- iFrameDone pulsed again mid-packet -> ignored. Exactly one packet and 4 reads.
- iEn dropped during byte 5 -> byte 5 completes, then idle high. No oFrameSent; oBusy=0 after that stop bit.
- iRst_N asserted during a data bit -> oUART_Tx=1 and all outputs 0 at once. A later iFrameDone restarts cleanly from header 0x55.
- iFrameDone with iEn=0 -> no activity, no reads, oBusy stays 0.

Source files
------------

// File: rtl/zfu_pkg.sv
// Shared constants and control-state type for the frame UART sender.
package zfu_pkg;

  localparam logic [7:0]  SYNC0     = 8'h55;
  localparam logic [7:0]  SYNC1     = 8'hAA;
  localparam int unsigned UART_BITS = 10;

  typedef enum logic [3:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StRdReq,
    StRdWait,
    StHi,
    StLo,
    StChk,
    StDone
  } zfuState_e;

endpackage

// File: rtl/z_uart_byte_tx.sv
// 8N1 byte serialiser: one start bit, eight data bits LSB first, one stop bit.
module z_uart_byte_tx
  import zfu_pkg::*;
#(
  parameter int unsigned CLK_DIV = 434
) (
  input  logic       iClk,
  input  logic       iRst_N,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic       oReady,
  output logic       oTx
);

  localparam int unsigned    DivW    = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [3:0]      BitLast = 4'(UART_BITS - 1);

  logic            busyQ;
  logic            txQ;
  logic [8:0]      shiftQ;
  logic [3:0]      bitCntQ;
  logic [DivW-1:0] divCntQ;

  logic lastDiv;
  logic lastBit;

  assign lastDiv = (divCntQ == DivLast);
  assign lastBit = (bitCntQ == BitLast);
  // Ready in the final stop-bit cycle so the next start bit follows with no gap.
  assign oReady  = !busyQ || (lastDiv && lastBit);
  assign oTx     = txQ;

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      busyQ   <= 1'b0;
      txQ     <= 1'b1;
      shiftQ  <= '1;
      bitCntQ <= '0;
      divCntQ <= '0;
    end else if (oReady && iValid) begin
      busyQ   <= 1'b1;
      txQ     <= 1'b0;
      shiftQ  <= {1'b1, iData};
      bitCntQ <= '0;
      divCntQ <= '0;
    end else if (busyQ) begin
      if (lastDiv) begin
        divCntQ <= '0;
        if (lastBit) begin
          busyQ <= 1'b0;
          txQ   <= 1'b1;
        end else begin
          txQ     <= shiftQ[0];
          shiftQ  <= {1'b1, shiftQ[8:1]};
          bitCntQ <= bitCntQ + 4'd1;
        end
      end else begin
        divCntQ <= divCntQ + 1'b1;
      end
    end
  end

endmodule

// File: rtl/z_frame_uart_sender.sv
// Reads one captured frame out of the FIFO and sends it as a sync/payload/checksum
// UART packet.
module z_frame_uart_sender
  import zfu_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 19200,
  parameter int unsigned CLK_DIV     = 434
) (
  input  logic        iClk,
  input  logic        iRst_N,
  input  logic        iEn,
  input  logic        iFrameDone,
  output logic        oFIFO_Rd_Clk,
  output logic        oFIFO_Rd_En,
  input  logic [15:0] iFIFO_Rd_Data,
  input  logic        iFIFO_Empty,
  output logic        oUART_Tx,
  output logic        oBusy,
  output logic        oFrameSent
);

  localparam int unsigned     CntW     = $clog2(FRAME_WORDS + 1);
  localparam logic [CntW-1:0] LastWord = CntW'(FRAME_WORDS - 1);

  zfuState_e       stateQ;
  logic [7:0]      pendDataQ;
  logic            pendValidQ;
  logic [15:0]     wordQ;
  logic [CntW-1:0] wordCntQ;
  logic [7:0]      chkQ;
  logic            rdEnQ;
  logic            busyQ;
  logic            frameSentQ;

  logic txValid;
  logic txReady;
  logic txTake;

  // Pending byte is withheld once iEn drops so only the byte in flight completes.
  assign txValid = pendValidQ && iEn;
  assign txTake  = txValid && txReady;

  assign oFIFO_Rd_Clk = iClk;
  assign oFIFO_Rd_En  = rdEnQ;
  assign oBusy        = busyQ;
  assign oFrameSent   = frameSentQ;

  z_uart_byte_tx #(
    .CLK_DIV(CLK_DIV)
  ) uByteTx (
    .iClk  (iClk),
    .iRst_N(iRst_N),
    .iData (pendDataQ),
    .iValid(txValid),
    .oReady(txReady),
    .oTx   (oUART_Tx)
  );

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      stateQ     <= StIdle;
      pendDataQ  <= '0;
      pendValidQ <= 1'b0;
      wordQ      <= '0;
      wordCntQ   <= '0;
      chkQ       <= '0;
      rdEnQ      <= 1'b0;
      busyQ      <= 1'b0;
      frameSentQ <= 1'b0;
    end else begin
      rdEnQ      <= 1'b0;
      frameSentQ <= 1'b0;
      if (txTake) pendValidQ <= 1'b0;

      if (stateQ != StIdle && !iEn) begin
        pendValidQ <= 1'b0;
        if (txReady) begin
          stateQ <= StIdle;
          busyQ  <= 1'b0;
        end
      end else begin
        unique case (stateQ)
          StIdle: begin
            if (iFrameDone && iEn) begin
              stateQ   <= StHdr0;
              busyQ    <= 1'b1;
              wordCntQ <= '0;
              chkQ     <= '0;
            end
          end
          StHdr0: begin
            if (!pendValidQ) begin
              pendDataQ  <= SYNC0;
              pendValidQ <= 1'b1;
              stateQ     <= StHdr1;
            end
          end
          StHdr1: begin
            if (!pendValidQ) begin
              pendDataQ  <= SYNC1;
              pendValidQ <= 1'b1;
              stateQ     <= StRdReq;
            end
          end
          StRdReq: begin
            if (!iFIFO_Empty) begin
              rdEnQ  <= 1'b1;
              stateQ <= StRdWait;
            end
          end
          StRdWait: begin
            // First cycle is the strobe itself; data is valid on the next one.
            if (!rdEnQ) begin
              wordQ  <= iFIFO_Rd_Data;
              chkQ   <= chkQ + iFIFO_Rd_Data[15:8] + iFIFO_Rd_Data[7:0];
              stateQ <= StHi;
            end
          end
          StHi: begin
            if (!pendValidQ) begin
              pendDataQ  <= wordQ[15:8];
              pendValidQ <= 1'b1;
              stateQ     <= StLo;
            end
          end
          StLo: begin
            if (!pendValidQ) begin
              pendDataQ  <= wordQ[7:0];
              pendValidQ <= 1'b1;
              wordCntQ   <= wordCntQ + 1'b1;
              stateQ     <= (wordCntQ == LastWord) ? StChk : StRdReq;
            end
          end
          StChk: begin
            if (!pendValidQ) begin
              pendDataQ  <= chkQ;
              pendValidQ <= 1'b1;
              stateQ     <= StDone;
            end
          end
          StDone: begin
            // With nothing pending, txReady marks the checksum's last stop-bit cycle.
            if (!pendValidQ && txReady) begin
              frameSentQ <= 1'b1;
              busyQ      <= 1'b0;
              stateQ     <= StIdle;
            end
          end
          default: stateQ <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_z_frame_uart_sender.sv
// Scoreboard bench: stimulus queues expected UART bytes, a decoder process checks them.
module tb_z_frame_uart_sender;

  localparam int FW  = 4;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rstN;
  logic        en;
  logic        frameDone;
  logic        rdClk;
  logic        rdEn;
  logic [15:0] rdData;
  logic        fifoEmpty;
  logic        tx;
  logic        busy;
  logic        sent;

  always #5 clk = ~clk;

  z_frame_uart_sender #(
    .FRAME_WORDS(FW),
    .CLK_DIV    (DIV)
  ) dut (
    .iClk         (clk),
    .iRst_N       (rstN),
    .iEn          (en),
    .iFrameDone   (frameDone),
    .oFIFO_Rd_Clk (rdClk),
    .oFIFO_Rd_En  (rdEn),
    .iFIFO_Rd_Data(rdData),
    .iFIFO_Empty  (fifoEmpty),
    .oUART_Tx     (tx),
    .oBusy        (busy),
    .oFrameSent   (sent)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: words become visible up to availLimit.
  logic [15:0] fifoMem [4];
  int          rp = 0;
  int          availLimit = 4;
  logic        fifoClr = 1'b0;
  assign fifoEmpty = (rp >= availLimit);
  always @(posedge clk) begin
    if (fifoClr) rp <= 0;
    else if (rdEn) begin
      rdData <= fifoMem[rp & 3];
      rp     <= rp + 1;
    end
  end

  logic [7:0] pkt [11];
  logic [7:0] expQ [$];

  // Monitor / UART decoder state.
  bit         decActive = 0;
  int         decCnt = 0;
  logic [7:0] decByte;
  logic [7:0] expByte;
  int         bytesSeen = 0;
  bit         armFirst = 0;
  int         firstFallCyc = 0;
  int         sentCount = 0;
  int         sentCyc = 0;
  int         rdCount = 0;
  int         rdEmptyErr = 0;

  always @(negedge clk) begin
    if (rdEn === 1'b1) begin
      rdCount++;
      if (fifoEmpty) rdEmptyErr++;
    end
    if (sent === 1'b1) begin
      sentCount++;
      sentCyc = cyc;
    end
    if (!rstN) begin
      decActive = 0;
    end else if (!decActive) begin
      if (tx === 1'b0) begin
        decActive = 1;
        decCnt    = 0;
        if (armFirst) begin
          firstFallCyc = cyc;
          armFirst     = 0;
        end
      end
    end else begin
      decCnt++;
      if (decCnt > DIV && decCnt < 9 * DIV && (decCnt % DIV) == DIV / 2) begin
        decByte[3'(decCnt / DIV - 1)] = tx;
      end else if (decCnt == 9 * DIV + DIV / 2) begin
        tests++;
        bytesSeen++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL uart_byte: got %02h with no byte expected", decByte);
        end else begin
          expByte = expQ.pop_front();
          if (decByte !== expByte || tx !== 1'b1) begin
            fails++;
            $display("FAIL uart_byte: got %02h stop=%b, expected %02h stop=1",
                     decByte, tx, expByte);
          end
        end
      end else if (decCnt == 10 * DIV - 1) begin
        decActive = 0;
      end
    end
  end

  int doneCyc;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic clearFifo();
    fifoClr = 1'b1;
    tick(1);
    fifoClr = 1'b0;
  endtask

  task automatic startFrame(input int nBytes);
    for (int i = 0; i < nBytes; i++) expQ.push_back(pkt[i]);
    armFirst  = 1;
    frameDone = 1'b1;
    doneCyc   = cyc;
    tick(1);
    frameDone = 1'b0;
  endtask

  task automatic waitBytes(input int target, input string name);
    int n = 0;
    while (bytesSeen < target && n < 3000) begin
      tick(1);
      n++;
    end
    if (bytesSeen < target) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout, bytes seen %0d expected %0d", name, bytesSeen, target);
    end
  endtask

  task automatic waitSent(input int s0, input string name);
    int n = 0;
    while (sentCount == s0 && n < 3000) begin
      tick(1);
      n++;
    end
    if (sentCount == s0) begin
      tests++;
      fails++;
      $display("FAIL %s: timeout waiting for frame sent, got 0 expected 1", name);
    end
  endtask

  int  rd0, s0, b0, rdSnap, n;
  bit  bad;

  initial begin
    pkt = '{8'h55, 8'hAA, 8'h12, 8'h34, 8'h00, 8'h01, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBE};
    fifoMem = '{16'h1234, 16'h0001, 16'hABCD, 16'h00FF};
    rstN = 1'b0;
    en = 1'b1;
    frameDone = 1'b0;
    tick(3);
    check("reset_tx", int'(tx), 1);
    check("reset_rd_en", int'(rdEn), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_frame_sent", int'(sent), 0);
    rstN = 1'b1;
    tick(2);

    // Normal packet.
    clearFifo();
    rd0 = rdCount; s0 = sentCount;
    startFrame(11);
    check("busy_after_start", int'(busy), 1);
    waitSent(s0, "normal_sent");
    check("start_latency", firstFallCyc - doneCyc, 3);
    check("packet_cycles", sentCyc - firstFallCyc, 11 * 10 * DIV);
    tick(5);
    check("normal_reads", rdCount - rd0, FW);
    check("normal_sent_count", sentCount - s0, 1);
    check("normal_busy_end", int'(busy), 0);
    check("normal_queue_empty", expQ.size(), 0);

    // FIFO stalls after two words.
    clearFifo();
    availLimit = 2;
    rd0 = rdCount; s0 = sentCount; b0 = bytesSeen;
    startFrame(11);
    waitBytes(b0 + 6, "stall_pre_bytes");
    tick(2 * DIV);
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      if (tx !== 1'b1 || busy !== 1'b1) bad = 1;
      tick(1);
    end
    check("stall_idle_high", int'(bad), 0);
    check("stall_reads_held", rdCount - rd0, 2);
    availLimit = 4;
    waitSent(s0, "stall_sent");
    tick(5);
    check("stall_reads", rdCount - rd0, FW);
    check("stall_queue_empty", expQ.size(), 0);

    // Second frame-done mid-packet is ignored.
    clearFifo();
    rd0 = rdCount; s0 = sentCount;
    startFrame(11);
    tick(150);
    frameDone = 1'b1;
    tick(1);
    frameDone = 1'b0;
    waitSent(s0, "redone_sent");
    tick(100);
    check("redone_reads", rdCount - rd0, FW);
    check("redone_sent_count", sentCount - s0, 1);
    check("redone_busy", int'(busy), 0);
    check("redone_queue_empty", expQ.size(), 0);

    // Enable dropped during byte 5.
    clearFifo();
    s0 = sentCount; b0 = bytesSeen;
    startFrame(6);
    waitBytes(b0 + 5, "abort_pre_bytes");
    tick(10);
    en = 1'b0;
    tick(2);
    check("abort_busy_during_byte", int'(busy), 1);
    rdSnap = rdCount;
    tick(100);
    check("abort_busy_after", int'(busy), 0);
    check("abort_tx_idle", int'(tx), 1);
    check("abort_no_sent", sentCount - s0, 0);
    check("abort_no_reads", rdCount - rdSnap, 0);
    check("abort_queue_empty", expQ.size(), 0);
    en = 1'b1;
    tick(5);

    // Reset in the middle of a data bit, then a clean restart.
    clearFifo();
    b0 = bytesSeen;
    startFrame(11);
    waitBytes(b0 + 3, "rst_pre_bytes");
    tick(8);
    rstN = 1'b0;
    #1;
    check("midrst_tx", int'(tx), 1);
    check("midrst_rd_en", int'(rdEn), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_frame_sent", int'(sent), 0);
    expQ.delete();
    tick(3);
    rstN = 1'b1;
    tick(3);
    clearFifo();
    s0 = sentCount;
    startFrame(11);
    waitSent(s0, "restart_sent");
    tick(5);
    check("restart_latency", firstFallCyc - doneCyc, 3);
    check("restart_queue_empty", expQ.size(), 0);

    // Frame-done with the block disabled.
    en = 1'b0;
    rd0 = rdCount; b0 = bytesSeen;
    frameDone = 1'b1;
    tick(1);
    frameDone = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (busy !== 1'b0 || tx !== 1'b1) bad = 1;
      tick(1);
    end
    check("disabled_no_activity", int'(bad), 0);
    check("disabled_no_reads", rdCount - rd0, 0);
    check("disabled_no_bytes", bytesSeen - b0, 0);
    en = 1'b1;

    check("rd_while_empty", rdEmptyErr, 0);
    n = tests;
    $display("[TB] %0d tests run, %0d failed", n, fails);
    $finish;
  end

endmodule
